// File: rtl/pu_alu_seq.sv
// rtl/pu_alu_seq.sv - micro-op table sequencer driving the PU ALU issue port
module pu_alu_seq #(
    parameter int FN_WIDTH   = 3,
    parameter int IMM_WIDTH  = 16,
    parameter int NUM_OPS    = 8,
    parameter int LOOP_WIDTH = 16,
    parameter int A_W        = $clog2(NUM_OPS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cfg_wr_en,
    input  logic [A_W-1:0]                cfg_wr_addr,
    input  logic [FN_WIDTH+IMM_WIDTH:0]   cfg_wr_data,
    input  logic [A_W:0]                  cfg_num_ops,
    input  logic [LOOP_WIDTH-1:0]         cfg_loop_count,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          op_valid,
    output logic                          op_ready,
    output logic                          alu_fn_valid,
    output logic [FN_WIDTH-1:0]           alu_fn,
    output logic [IMM_WIDTH-1:0]          alu_imm,
    output logic                          alu_in1_src,
    output logic                          alu_out_valid,
    output logic                          alu_out_last
);

    localparam int E_W = 1 + FN_WIDTH + IMM_WIDTH;
    localparam logic [A_W:0] MAX_OPS = (A_W+1)'(NUM_OPS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [E_W-1:0]         tbl_q [NUM_OPS];
    logic [E_W-1:0]         tbl_d [NUM_OPS];
    logic [A_W:0]           num_ops_q, num_ops_d;
    logic [LOOP_WIDTH-1:0]  loop_q, loop_d;
    logic [LOOP_WIDTH-1:0]  iter_q, iter_d;
    logic [A_W-1:0]         op_idx_q, op_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   op_ready_q, op_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;

    logic                   issue;
    logic                   last_op;
    logic                   last_iter;
    logic                   last_issue;
    logic                   cfg_bad;
    logic [E_W-1:0]         entry;

    assign issue      = op_valid && (state_q == S_ISSUE);
    assign entry      = tbl_q[op_idx_q];
    // Compare against the terminal values before incrementing so a full-scale
    // loop count never needs an extra counter bit.
    assign last_op    = ({1'b0, op_idx_q} == (num_ops_q - (A_W+1)'(1)));
    assign last_iter  = (iter_q == (loop_q - LOOP_WIDTH'(1)));
    assign last_issue = issue && last_op && last_iter;
    assign cfg_bad    = (cfg_num_ops == '0) || (cfg_loop_count == '0) ||
                        (cfg_num_ops > MAX_OPS);

    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        num_ops_d   = num_ops_q;
        loop_d      = loop_q;
        iter_d      = iter_q;
        op_idx_d    = op_idx_q;
        busy_d      = busy_q;
        op_ready_d  = op_ready_q;
        done_d      = 1'b0;
        out_valid_d = issue;
        out_last_d  = last_issue;

        if (cfg_wr_en && (state_q == S_IDLE)) begin
            tbl_d[cfg_wr_addr] = cfg_wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        done_d = 1'b1;
                    end else begin
                        num_ops_d  = cfg_num_ops;
                        loop_d     = cfg_loop_count;
                        op_idx_d   = '0;
                        iter_d     = '0;
                        state_d    = S_ISSUE;
                        busy_d     = 1'b1;
                        op_ready_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d    = S_DRAIN;
                        op_ready_d = 1'b0;
                        done_d     = 1'b1;
                        op_idx_d   = '0;
                    end else if (last_op) begin
                        op_idx_d = '0;
                        iter_d   = iter_q + LOOP_WIDTH'(1);
                    end else begin
                        op_idx_d = op_idx_q + A_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                op_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tbl_q       <= '{default: '0};
            num_ops_q   <= '0;
            loop_q      <= '0;
            iter_q      <= '0;
            op_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            num_ops_q   <= num_ops_d;
            loop_q      <= loop_d;
            iter_q      <= iter_d;
            op_idx_q    <= op_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            op_ready_q  <= op_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // The ALU must see a NOP whenever nothing is issued.
    assign alu_fn_valid  = issue;
    assign alu_fn        = issue ? entry[IMM_WIDTH +: FN_WIDTH] : '0;
    assign alu_imm       = issue ? entry[IMM_WIDTH-1:0] : '0;
    assign alu_in1_src   = issue ? entry[E_W-1] : 1'b0;

    assign busy          = busy_q;
    assign done          = done_q;
    assign op_ready      = op_ready_q;
    assign alu_out_valid = out_valid_q;
    assign alu_out_last  = out_last_q;

endmodule

// File: tb/tb_pu_alu_seq.sv
// tb/tb_pu_alu_seq.sv - scoreboard bench for pu_alu_seq
module tb_pu_alu_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_wr_en;
    logic [2:0]  cfg_wr_addr;
    logic [19:0] cfg_wr_data;
    logic [3:0]  cfg_num_ops;
    logic [15:0] cfg_loop_count;
    logic        start;
    logic        start4;
    logic        op_valid;
    logic        busy, done, op_ready, alu_fn_valid, alu_in1_src;
    logic        alu_out_valid, alu_out_last;
    logic [2:0]  alu_fn;
    logic [15:0] alu_imm;
    logic        d4_busy, d4_done, d4_op_ready, d4_fn_valid, d4_src;
    logic        d4_out_valid, d4_out_last;
    logic [2:0]  d4_fn;
    logic [15:0] d4_imm;

    int n_vec = 0;
    int n_err = 0;
    logic [19:0] tbl_m [8];
    logic [20:0] exp_q [$];

    always #5 clk = ~clk;

    pu_alu_seq dut (
        .clk(clk), .resetn(resetn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_num_ops(cfg_num_ops), .cfg_loop_count(cfg_loop_count),
        .start(start), .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready),
        .alu_fn_valid(alu_fn_valid), .alu_fn(alu_fn), .alu_imm(alu_imm),
        .alu_in1_src(alu_in1_src), .alu_out_valid(alu_out_valid),
        .alu_out_last(alu_out_last)
    );

    pu_alu_seq #(.LOOP_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_num_ops(cfg_num_ops), .cfg_loop_count(cfg_loop_count[3:0]),
        .start(start4), .busy(d4_busy), .done(d4_done),
        .op_valid(op_valid), .op_ready(d4_op_ready),
        .alu_fn_valid(d4_fn_valid), .alu_fn(d4_fn), .alu_imm(d4_imm),
        .alu_in1_src(d4_src), .alu_out_valid(d4_out_valid),
        .alu_out_last(d4_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [19:0] d);
        @(posedge clk); #1;
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        tbl_m[a] = d;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic run(input int n, input int l, input int slo, input int shi,
                       input bit wr0, input logic [19:0] wr0_data,
                       input bit busy_poke, input int exp_done, output int issues);
        bit         live;
        logic       pv, pl;
        logic [20:0] e;
        live = (n > 0) && (n <= 8) && (l > 0);
        if (wr0) tbl_m[0] = wr0_data;
        if (live) begin
            for (int it = 0; it < l; it++)
                for (int k = 0; k < n; k++)
                    exp_q.push_back({(it == l-1) && (k == n-1), tbl_m[k]});
        end
        @(posedge clk); #1;
        start = 1'b1; cfg_num_ops = 4'(n); cfg_loop_count = 16'(l); op_valid = 1'b1;
        cfg_wr_en = wr0; cfg_wr_addr = 3'd0; cfg_wr_data = wr0_data;
        @(negedge clk);
        chk("busy_c0", busy, 1'b0);
        pv = 1'b0; pl = 1'b0; issues = 0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(posedge clk); #1;
            start = busy_poke && (c == 2);
            cfg_wr_en = busy_poke && (c == 2);
            cfg_wr_addr = 3'd1; cfg_wr_data = 20'hFFFFF;
            op_valid = !((c >= slo) && (c <= shi));
            @(negedge clk);
            chk("out_valid", alu_out_valid, pv);
            chk("out_last", alu_out_last, pl);
            chk("busy", busy, live && (c <= exp_done));
            chk("op_ready", op_ready, live && (c < exp_done));
            chk("done", done, (c == exp_done));
            if (alu_fn_valid) begin
                issues++;
                chk("q_underflow", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("fn", alu_fn, e[18:16]);
                    chk("imm", alu_imm, e[15:0]);
                    chk("src", alu_in1_src, e[19]);
                    pl = e[20];
                end
            end else begin
                chk("nop_gate", {alu_in1_src, alu_fn, alu_imm}, 20'h0);
                pl = 1'b0;
            end
            pv = alu_fn_valid;
        end
        start = 1'b0; cfg_wr_en = 1'b0; op_valid = 1'b0;
        chk("q_drained", exp_q.size(), 0);
    endtask

    initial begin
        int iss, cnt, dc;
        resetn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_num_ops = '0; cfg_loop_count = '0; start = 1'b0; start4 = 1'b0; op_valid = 1'b1;
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, op_ready, alu_fn_valid, alu_out_valid, alu_out_last}, 6'h0);
        chk("rst_issue", {alu_in1_src, alu_fn, alu_imm}, 20'h0);
        resetn = 1'b1;
        op_valid = 1'b0;

        wr(3'd0, {1'b1, 3'd1, 16'd5});
        wr(3'd1, {1'b0, 3'd3, 16'h1234});
        wr(3'd2, {1'b1, 3'd7, 16'd3});

        run(3, 2, 0, -1, 1'b0, '0, 1'b0, 7, iss);
        chk("basic_issues", iss, 6);
        run(3, 2, 2, 3, 1'b0, '0, 1'b0, 9, iss);
        chk("stall_issues", iss, 6);

        run(0, 2, 0, -1, 1'b0, '0, 1'b0, 1, iss);
        chk("degen_n0", iss, 0);
        run(3, 0, 0, -1, 1'b0, '0, 1'b0, 1, iss);
        chk("degen_l0", iss, 0);
        run(9, 2, 0, -1, 1'b0, '0, 1'b0, 1, iss);
        chk("degen_n9", iss, 0);

        run(3, 1, 0, -1, 1'b1, {1'b0, 3'd2, 16'd7}, 1'b0, 4, iss);
        chk("collide_issues", iss, 3);
        run(3, 2, 0, -1, 1'b0, '0, 1'b1, 7, iss);
        chk("poke_issues", iss, 6);
        run(3, 1, 0, -1, 1'b0, '0, 1'b0, 4, iss);
        chk("after_poke", iss, 3);

        for (int i = 3; i < 8; i++) wr(3'(i), {i[0], 3'(i), 16'(16'h100 * i + 1)});
        run(8, 3, 0, -1, 1'b0, '0, 1'b0, 25, iss);
        chk("wrap_issues", iss, 24);

        @(posedge clk); #1;
        start4 = 1'b1; cfg_num_ops = 4'd8; cfg_loop_count = 16'd15; op_valid = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cnt = 0; dc = -1;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (d4_fn_valid) cnt++;
            if (d4_done && (dc < 0)) dc = c;
            @(posedge clk); #1;
        end
        chk("lw4_issues", cnt, 120);
        chk("lw4_done_cycle", dc, 121);

        @(posedge clk); #1;
        start = 1'b1; cfg_num_ops = 4'd3; cfg_loop_count = 16'd4; op_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_outs", {busy, done, op_ready, alu_fn_valid, alu_out_valid, alu_out_last}, 6'h0);
        chk("midrst_issue", {alu_in1_src, alu_fn, alu_imm}, 20'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;
        run(3, 1, 0, -1, 1'b0, '0, 1'b0, 4, iss);
        chk("nop_table_issues", iss, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
